// File: rtl/sh_ibus_arbiter_pkg.sv
// Shared types and constants for the SH-2 internal bus arbiter and its pick logic.
// Master bundle struct packs one requester's flattened IBUS fields.
package sh_ibus_arbiter_pkg;

  localparam int ARB_MODE_FIXED = 0;
  localparam int ARB_MODE_RR    = 1;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] dout;
    logic [3:0]  ba;
    logic        we;
    logic        req;
    logic        lock;
  } ibus_m_t;

endpackage

// File: rtl/sh_ibus_arbiter_if.sv
// IBUS arbiter bundle: flattened master-side fields plus the single slave port.
// 'master' is the arbiter's view, 'slave' is the view of the surrounding fabric.
interface sh_ibus_arbiter_if #(
  parameter int NUM_M = 2
);
  logic [NUM_M*32-1:0] M_A;
  logic [NUM_M*32-1:0] M_DO;
  logic [NUM_M*4-1:0]  M_BA;
  logic [NUM_M-1:0]    M_WE;
  logic [NUM_M-1:0]    M_REQ;
  logic [NUM_M-1:0]    M_LOCK;
  logic [31:0]         M_DI;
  logic [NUM_M-1:0]    M_WAIT;
  logic [31:0]         S_A;
  logic [31:0]         S_DO;
  logic [3:0]          S_BA;
  logic                S_WE;
  logic                S_REQ;
  logic                S_LOCK;
  logic [31:0]         S_DI;
  logic                S_BUSY;
  logic [NUM_M-1:0]    GNT;
  logic                BUS_IDLE;

  modport master (
    input  M_A, M_DO, M_BA, M_WE, M_REQ, M_LOCK, S_DI, S_BUSY,
    output M_DI, M_WAIT, S_A, S_DO, S_BA, S_WE, S_REQ, S_LOCK, GNT, BUS_IDLE
  );

  modport slave (
    output M_A, M_DO, M_BA, M_WE, M_REQ, M_LOCK, S_DI, S_BUSY,
    input  M_DI, M_WAIT, S_A, S_DO, S_BA, S_WE, S_REQ, S_LOCK, GNT, BUS_IDLE
  );
endinterface

// File: rtl/sh_arb_pick.sv
// Combinational winner selection: boosted-first lowest index, or round-robin from ptr+1.
// Returns a one-hot winner and its index; reusable for DMAC channel arbitration.
module sh_arb_pick #(
  parameter int N = 2
) (
  input  logic                 rr_mode,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         boost,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         win,
  output logic [$clog2(N)-1:0] win_idx
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  cand;
  logic [IW-1:0] idx;
  logic          found;

  // NOTE: every output and temporary gets a default before any branch, so no latch is inferred.
  always_comb begin
    win     = '0;
    win_idx = '0;
    idx     = '0;
    found   = 1'b0;
    cand    = (|(req & boost)) ? (req & boost) : req;
    if (rr_mode) begin
      for (int k = 1; k <= N; k++) begin
        idx = IW'((int'(ptr) + k) % N);
        if (!found && req[idx]) begin
          found    = 1'b1;
          win[idx] = 1'b1;
          win_idx  = idx;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!found && cand[i]) begin
          found   = 1'b1;
          win[i]  = 1'b1;
          win_idx = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/sh_ibus_arbiter.sv
// N-master IBUS arbiter: fixed priority with starvation boost or round-robin,
// bus lock for TAS read-modify-write, optional grant parking.
module sh_ibus_arbiter
  import sh_ibus_arbiter_pkg::*;
#(
  parameter int NUM_M        = 2,
  parameter int MODE         = ARB_MODE_FIXED,
  parameter int STARVE_LIMIT = 0,
  parameter int PARK         = 1
) (
  input logic               CLK,
  input logic               RST_N,
  input logic               CE_R,
  input logic               RES_N,
  sh_ibus_arbiter_if.master bus
);
  localparam int            IW      = $clog2(NUM_M);
  localparam int            CW      = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

  ibus_m_t          m [NUM_M];
  ibus_m_t          own;
  logic [NUM_M-1:0] req, boost, win;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    ptr_q, ptr_d, win_idx;
  logic [CW-1:0]    cnt_q [NUM_M];
  logic [CW-1:0]    cnt_d [NUM_M];
  logic             arb_pt;

  // Unpack the flattened ports; the owner's bundle is selected by the one-hot grant.
  always_comb begin
    own = '0;
    for (int i = 0; i < NUM_M; i++) begin
      m[i] = '{a:    bus.M_A[32*i +: 32],
               dout: bus.M_DO[32*i +: 32],
               ba:   bus.M_BA[4*i +: 4],
               we:   bus.M_WE[i],
               req:  bus.M_REQ[i],
               lock: bus.M_LOCK[i]};
      req[i]   = m[i].req;
      boost[i] = (MODE == ARB_MODE_FIXED) && (STARVE_LIMIT > 0) && (cnt_q[i] == CNT_MAX);
      if (gnt_q[i]) own = m[i];
    end
  end

  assign bus.S_A      = own.a;
  assign bus.S_DO     = own.dout;
  assign bus.S_BA     = own.ba;
  assign bus.S_WE     = own.we;
  assign bus.S_REQ    = own.req;
  assign bus.S_LOCK   = own.lock;
  assign bus.M_DI     = bus.S_DI;
  assign bus.M_WAIT   = req & (~gnt_q | {NUM_M{bus.S_BUSY}});
  assign bus.GNT      = gnt_q;
  assign bus.BUS_IDLE = ~(own.req | own.lock);

  // A locked owner freezes the grant even across REQ gaps.
  assign arb_pt = ~(|gnt_q) | (~bus.S_BUSY & ~own.lock);

  sh_arb_pick #(.N(NUM_M)) u_pick (
    .rr_mode (MODE == ARB_MODE_RR),
    .req     (req),
    .boost   (boost),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx)
  );

  always_comb begin
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (arb_pt) begin
      if (|req) begin
        gnt_d = win;
        ptr_d = win_idx;
      end else if (PARK == 0) begin
        gnt_d = '0;
      end
    end
    for (int i = 0; i < NUM_M; i++) begin
      if (!req[i] || (arb_pt && win[i])) begin
        cnt_d[i] = '0;
      end else if (arb_pt && cnt_q[i] != CNT_MAX) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  // NOTE: the starvation counter array is reset because stale counts would grant a boost.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      gnt_q <= '0;
      ptr_q <= IW'(NUM_M - 1);
      cnt_q <= '{default: '0};
    end else if (CE_R) begin
      if (!RES_N) begin
        gnt_q <= '0;
        ptr_q <= IW'(NUM_M - 1);
        cnt_q <= '{default: '0};
      end else begin
        gnt_q <= gnt_d;
        ptr_q <= ptr_d;
        cnt_q <= cnt_d;
      end
    end
  end

  // A waiting master must hold its address, data, byte enables and direction.
  for (genvar g = 0; g < NUM_M; g++) begin : g_hold_chk
    a_hold_fields: assert property (@(posedge CLK) disable iff (!RST_N)
      (bus.M_REQ[g] && bus.M_WAIT[g]) |=>
        $stable({bus.M_A[32*g +: 32], bus.M_DO[32*g +: 32], bus.M_BA[4*g +: 4], bus.M_WE[g]}));
  end

endmodule

// File: tb/tb_sh_ibus_arbiter.sv
// Directed bench for sh_ibus_arbiter: three configurations share one clock and reset.
// ia: 2 masters fixed/no park, ib: 3 masters round-robin/park, ic: 2 masters fixed with boost.
module tb_sh_ibus_arbiter;
  import sh_ibus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_n, ce_r, res_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  sh_ibus_arbiter_if #(.NUM_M(2)) ia ();
  sh_ibus_arbiter_if #(.NUM_M(3)) ib ();
  sh_ibus_arbiter_if #(.NUM_M(2)) ic ();

  sh_ibus_arbiter #(.NUM_M(2), .MODE(ARB_MODE_FIXED), .STARVE_LIMIT(0), .PARK(0)) u_a (
    .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .RES_N(res_n), .bus(ia));
  sh_ibus_arbiter #(.NUM_M(3), .MODE(ARB_MODE_RR), .STARVE_LIMIT(0), .PARK(1)) u_b (
    .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .RES_N(res_n), .bus(ib));
  sh_ibus_arbiter #(.NUM_M(2), .MODE(ARB_MODE_FIXED), .STARVE_LIMIT(2), .PARK(1)) u_c (
    .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .RES_N(res_n), .bus(ic));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] rr_exp [6];
  logic [1:0] sv_exp [6];

  initial begin
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    sv_exp = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};

    rst_n = 1'b0;
    ce_r  = 1'b1;
    res_n = 1'b1;
    ia.M_A = {32'hA100_0004, 32'hA000_0000};
    ia.M_DO = {32'h1111_2222, 32'h3333_4444};
    ia.M_BA = 8'hF3;
    ia.M_WE = '0;
    ia.M_REQ = 2'b01;
    ia.M_LOCK = '0;
    ia.S_DI = 32'hCAFE_0001;
    ia.S_BUSY = 1'b0;
    ib.M_A = {32'hB000_0200, 32'hB000_0100, 32'hB000_0000};
    ib.M_DO = '0;
    ib.M_BA = '1;
    ib.M_WE = '0;
    ib.M_REQ = '0;
    ib.M_LOCK = '0;
    ib.S_DI = '0;
    ib.S_BUSY = 1'b0;
    ic.M_A = {32'hC000_0100, 32'hC000_0000};
    ic.M_DO = '0;
    ic.M_BA = '1;
    ic.M_WE = '0;
    ic.M_REQ = '0;
    ic.M_LOCK = '0;
    ic.S_DI = '0;
    ic.S_BUSY = 1'b0;

    // Outputs while held in reset with M0 already requesting.
    repeat (2) tick();
    check("rst_gnt", ia.GNT, 0);
    check("rst_sreq", ia.S_REQ, 0);
    check("rst_sa", ia.S_A, 0);
    check("rst_wait", ia.M_WAIT, 2'b01);
    check("rst_idle", ia.BUS_IDLE, 1);
    check("rst_gnt_b", ib.GNT, 0);

    rst_n = 1'b1;
    ce_r  = 1'b0;
    tick();
    check("ce_hold", ia.GNT, 0);
    ce_r = 1'b1;

    // Single read with two busy cycles, no parking.
    tick();
    check("t1_gnt", ia.GNT, 2'b01);
    ia.S_BUSY = 1'b1;
    #1;
    check("t1_sreq", ia.S_REQ, 1);
    check("t1_sa", ia.S_A, 32'hA000_0000);
    check("t1_sba", ia.S_BA, 4'h3);
    check("t1_wait_a", ia.M_WAIT, 2'b01);
    tick();
    check("t1_wait_b", ia.M_WAIT, 2'b01);
    ia.S_BUSY = 1'b0;
    #1;
    check("t1_wait_c", ia.M_WAIT, 2'b00);
    check("t1_di", ia.M_DI, 32'hCAFE_0001);
    tick();
    ia.M_REQ = 2'b00;
    #1;
    check("t1_idle", ia.BUS_IDLE, 1);
    tick();
    check("t1_release", ia.GNT, 2'b00);

    // Both masters request together: M0 first, then M1; later M1 hands over back-to-back.
    ia.M_REQ = 2'b11;
    #1;
    check("t2_wait_pre", ia.M_WAIT, 2'b11);
    tick();
    check("t2_gnt0", ia.GNT, 2'b01);
    ia.S_BUSY = 1'b1;
    #1;
    check("t2_wait_a", ia.M_WAIT, 2'b11);
    tick();
    ia.S_BUSY = 1'b0;
    #1;
    check("t2_wait_b", ia.M_WAIT, 2'b10);
    tick();
    ia.M_REQ = 2'b10;
    tick();
    check("t2_gnt1", ia.GNT, 2'b10);
    ia.S_BUSY = 1'b1;
    ia.M_REQ = 2'b11;
    #1;
    check("t2_sa1", ia.S_A, 32'hA100_0004);
    check("t2_sdo1", ia.S_DO, 32'h1111_2222);
    check("t2_wait_d", ia.M_WAIT, 2'b11);
    tick();
    ia.S_BUSY = 1'b0;
    #1;
    check("t2_wait_e", ia.M_WAIT, 2'b01);
    tick();
    ia.M_REQ = 2'b01;
    #1;
    check("t2_handover", ia.GNT, 2'b01);
    check("t2_sreq_b2b", ia.S_REQ, 1);
    check("t2_sa0", ia.S_A, 32'hA000_0000);
    check("t2_wait_f", ia.M_WAIT, 2'b00);
    tick();
    ia.M_REQ = 2'b00;
    tick();
    check("t2_release", ia.GNT, 2'b00);

    // Locked read / two idle cycles / locked write by M1 while M0 keeps requesting.
    ia.M_LOCK = 2'b10;
    ia.M_REQ  = 2'b10;
    tick();
    check("lk_gnt", ia.GNT, 2'b10);
    ia.M_REQ = 2'b11;
    #1;
    check("lk_slock", ia.S_LOCK, 1);
    check("lk_wait_a", ia.M_WAIT, 2'b01);
    tick();
    ia.M_REQ = 2'b01;
    #1;
    check("lk_idle", ia.BUS_IDLE, 0);
    check("lk_wait_b", ia.M_WAIT, 2'b01);
    tick();
    check("lk_gap1", ia.GNT, 2'b10);
    tick();
    check("lk_gap2", ia.GNT, 2'b10);
    ia.M_WE  = 2'b10;
    ia.M_REQ = 2'b11;
    #1;
    check("lk_we", ia.S_WE, 1);
    check("lk_wait_c", ia.M_WAIT, 2'b01);
    tick();
    check("lk_hold", ia.GNT, 2'b10);
    ia.M_REQ  = 2'b01;
    ia.M_LOCK = 2'b00;
    ia.M_WE   = 2'b00;
    #1;
    check("lk_idle2", ia.BUS_IDLE, 1);
    check("lk_wait_d", ia.M_WAIT, 2'b01);
    tick();
    check("lk_regrant", ia.GNT, 2'b01);
    check("lk_wait_e", ia.M_WAIT, 2'b00);
    tick();
    ia.M_REQ = 2'b00;
    tick();
    check("lk_release", ia.GNT, 2'b00);

    // Round-robin with all three requesting continuously, zero-wait slave.
    ib.M_REQ = 3'b111;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rr_gnt%0d", k), ib.GNT, rr_exp[k]);
    end
    ib.M_REQ = 3'b101;
    tick();
    check("rr_skip_a", ib.GNT, 3'b001);
    tick();
    check("rr_skip_b", ib.GNT, 3'b100);
    ib.M_REQ = 3'b000;
    tick();
    check("park_hold", ib.GNT, 3'b100);
    check("park_idle", ib.BUS_IDLE, 1);
    ib.M_REQ = 3'b100;
    #1;
    check("park_sreq", ib.S_REQ, 1);
    check("park_wait", ib.M_WAIT, 3'b000);
    tick();
    ib.M_REQ = 3'b000;

    // Starvation boost after two lost arbitrations; the counter restarts on grant.
    ic.M_REQ = 2'b11;
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("sv_gnt%0d", k), ic.GNT, sv_exp[k]);
    end
    ic.M_REQ = 2'b00;
    tick();

    // Asynchronous reset in the middle of a busy M1 access.
    ia.M_REQ = 2'b10;
    tick();
    check("rs_gnt", ia.GNT, 2'b10);
    ia.S_BUSY = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("rs_gnt0", ia.GNT, 2'b00);
    check("rs_sreq", ia.S_REQ, 0);
    check("rs_idle", ia.BUS_IDLE, 1);
    check("rs_wait", ia.M_WAIT, 2'b10);
    tick();
    rst_n = 1'b1;
    tick();
    check("rs_regrant", ia.GNT, 2'b10);

    // Synchronous soft reset takes effect at the next enabled edge.
    res_n = 1'b0;
    #1;
    check("sr_before", ia.GNT, 2'b10);
    tick();
    check("sr_gnt0", ia.GNT, 2'b00);
    check("sr_sreq", ia.S_REQ, 0);
    check("sr_idle", ia.BUS_IDLE, 1);
    res_n = 1'b1;
    tick();
    check("sr_regrant", ia.GNT, 2'b10);
    ia.S_BUSY = 1'b0;
    tick();
    ia.M_REQ = 2'b00;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
